tile_fetch: RTL and testbench

TILE_FETCH -- requirements
Module: tile_fetch

---
 rtl/tile_fetch_pkg.sv | 28 ++
 rtl/tile_fetch_board_map.sv | 36 +++
 rtl/tile_fetch.sv | 152 +++++++++++++++
 tb/tb_tile_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_fetch_pkg.sv
// tile_fetch_pkg: shared constants, FSM state type and cell-index helper for
// the tile fetch pipeline and its board map.
//   BOARD_COLS/BOARD_ROWS : playfield size in cells
//   TILE_PX               : tile edge length in pixels
//   TILE_W                : width of a tile index stored in the map
//   CELLS/IDX_W           : map depth and the width of its address
package tile_fetch_pkg;

    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    localparam int TILE_PX    = 16;
    localparam int TILE_W     = 4;
    localparam int CELLS      = BOARD_COLS * BOARD_ROWS;
    localparam int IDX_W      = $clog2(CELLS);

    typedef logic [IDX_W-1:0] cell_idx_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } fsm_state_t;

    // Row-major cell index: row * BOARD_COLS + col.
    function automatic cell_idx_t cell_index(input logic [5:0] row, input logic [5:0] col);
        return cell_idx_t'(row) * cell_idx_t'(BOARD_COLS) + cell_idx_t'(col);
    endfunction

endpackage

// File: rtl/tile_fetch_board_map.sv
// board_map: 200 x 4-bit board cell storage, one synchronous read port and
// one write port.
//   clk, rst  : clock, async active-high reset (read register only)
//   raddr_i   : read address, data appears on rdata_o after the next edge
//   rdata_o   : registered read data
//   we_i, waddr_i, wdata_i : write port
// A read and a write to the same entry in one cycle returns the old value.
// The storage itself has no reset; the owner clears it with a sweep.
module board_map
    import tile_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  cell_idx_t         raddr_i,
    output logic [TILE_W-1:0] rdata_o,
    input  logic              we_i,
    input  cell_idx_t         waddr_i,
    input  logic [TILE_W-1:0] wdata_i
);

    logic [TILE_W-1:0] mem_q [CELLS];
    logic [TILE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read register is part of the pixel pipeline, so it does take reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tile_fetch.sv
// tile_fetch: converts active-area pixel coordinates into tile-RAM reads and
// produces the final pixel colour three cycles later, with timing aligned.
//   clk, rst                 : clock, async active-high reset
//   de_i, hs_i, vs_i         : display enable and syncs from the timing gen
//   hcnt, vcnt               : active-area column / row
//   cell_we, cell_x, cell_y, cell_tile : board map write port
//   board_clr, clr_busy      : clear request / clear in progress
//   ram_ren, ram_raddr       : tile-RAM read request ({tile, py, px})
//   ram_rdata                : tile-RAM data, one cycle after ram_ren
//   rgb, de_o, hs_o, vs_o    : pixel output, 3 cycles after the inputs
// Pipeline: stage 1 = map read + pixel offsets, stage 2 = RAM access,
// stage 3 = output register.
module tile_fetch
    import tile_fetch_pkg::*;
#(
    parameter int          BOARD_X0 = 240,
    parameter int          BOARD_Y0 = 80,
    parameter logic [11:0] BG_RGB   = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_i,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    input  logic        cell_we,
    input  logic [3:0]  cell_x,
    input  logic [4:0]  cell_y,
    input  logic [3:0]  cell_tile,
    input  logic        board_clr,
    output logic        clr_busy,
    output logic        ram_ren,
    output logic [11:0] ram_raddr,
    input  logic [11:0] ram_rdata,
    output logic [11:0] rgb,
    output logic        de_o,
    output logic        hs_o,
    output logic        vs_o
);

    localparam logic [9:0] X0 = 10'(BOARD_X0);
    localparam logic [9:0] X1 = 10'(BOARD_X0 + BOARD_COLS * TILE_PX);
    localparam logic [9:0] Y0 = 10'(BOARD_Y0);
    localparam logic [9:0] Y1 = 10'(BOARD_Y0 + BOARD_ROWS * TILE_PX);

    logic [9:0]        hoff, voff;
    logic              in_board;
    cell_idx_t         rd_idx, wr_idx;
    logic              cell_ok;

    fsm_state_t        state_q, state_d;
    cell_idx_t         cnt_q, cnt_d;
    logic              map_we;
    cell_idx_t         map_waddr;
    logic [TILE_W-1:0] map_wdata;
    logic [TILE_W-1:0] tile;

    logic [3:0]        px_q, py_q;
    logic [1:0]        inb_q;              // [0] stage 1, [1] stage 2
    logic [2:0]        de_q, hs_q, vs_q;   // [2] is the output stage
    logic [11:0]       rgb_q;

    // ---------------- address generation ----------------
    assign hoff     = hcnt - X0;
    assign voff     = vcnt - Y0;
    assign in_board = de_i && (hcnt >= X0) && (hcnt < X1) && (vcnt >= Y0) && (vcnt < Y1);
    // Off-board pixels read entry 0 so the map address never leaves 0..199.
    assign rd_idx   = in_board ? cell_index(voff[9:4], hoff[9:4]) : '0;

    assign cell_ok  = (cell_x < 4'(BOARD_COLS)) && (cell_y < 5'(BOARD_ROWS));
    assign wr_idx   = cell_index({1'b0, cell_y}, {2'b0, cell_x});

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The clear sweep owns the write port, so cell writes and further clear
    // requests are simply not looked at while it runs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        map_we    = 1'b0;
        map_waddr = wr_idx;
        map_wdata = cell_tile;
        case (state_q)
            ST_IDLE: begin
                map_we = cell_we && cell_ok;
                if (board_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                map_we    = 1'b1;
                map_waddr = cnt_q;
                map_wdata = '0;
                if (cnt_q == cell_idx_t'(CELLS - 1)) state_d = ST_IDLE;
                else                                 cnt_d   = cnt_q + cell_idx_t'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign clr_busy = (state_q == ST_CLEAR);

    board_map u_map (
        .clk     (clk),
        .rst     (rst),
        .raddr_i (rd_idx),
        .rdata_o (tile),
        .we_i    (map_we),
        .waddr_i (map_waddr),
        .wdata_i (map_wdata)
    );

    // ---------------- pixel pipeline ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q  <= '0;
            py_q  <= '0;
            inb_q <= '0;
            de_q  <= '0;
            hs_q  <= '0;
            vs_q  <= '0;
            rgb_q <= '0;
        end else begin
            px_q  <= hoff[3:0];
            py_q  <= voff[3:0];
            inb_q <= {inb_q[0], in_board};
            de_q  <= {de_q[1:0], de_i};
            hs_q  <= {hs_q[1:0], hs_i};
            vs_q  <= {vs_q[1:0], vs_i};
            rgb_q <= inb_q[1] ? ram_rdata : (de_q[1] ? BG_RGB : 12'h000);
        end
    end

    assign ram_ren   = inb_q[0];
    assign ram_raddr = {tile, py_q, px_q};
    assign rgb       = rgb_q;
    assign de_o      = de_q[2];
    assign hs_o      = hs_q[2];
    assign vs_o      = vs_q[2];

endmodule

// File: tb/tb_tile_fetch.sv
// Directed + randomized bench for tile_fetch. Pixel expectations are queued
// with their due cycle when driven and compared when the output arrives.
module tb_tile_fetch;

    localparam logic [11:0] BG = 12'h3C7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic [9:0]  hcnt = '0, vcnt = '0;
    logic        cell_we = 1'b0;
    logic [3:0]  cell_x = '0;
    logic [4:0]  cell_y = '0;
    logic [3:0]  cell_tile = '0;
    logic        board_clr = 1'b0;
    logic        clr_busy;
    logic        ram_ren;
    logic [11:0] ram_raddr;
    logic [11:0] ram_rdata = '0;
    logic [11:0] rgb;
    logic        de_o, hs_o, vs_o;

    tile_fetch #(.BOARD_X0(240), .BOARD_Y0(80), .BG_RGB(BG)) dut (
        .clk       (clk),
        .rst       (rst),
        .de_i      (de_i),
        .hs_i      (hs_i),
        .vs_i      (vs_i),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .cell_we   (cell_we),
        .cell_x    (cell_x),
        .cell_y    (cell_y),
        .cell_tile (cell_tile),
        .board_clr (board_clr),
        .clr_busy  (clr_busy),
        .ram_ren   (ram_ren),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .rgb       (rgb),
        .de_o      (de_o),
        .hs_o      (hs_o),
        .vs_o      (vs_o)
    );

    always #5 clk = ~clk;

    // Tile RAM model: registered read, contents are a fixed scramble of the address.
    function automatic logic [11:0] rom(input logic [11:0] a);
        return {a[3:0], a[11:8], a[7:4]} ^ 12'h5A3;
    endfunction

    always @(posedge clk) if (ram_ren) ram_rdata <= rom(ram_raddr);

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference board + scoreboard ----------------
    logic [3:0] mmap [200];

    typedef struct {
        int          due;
        logic [14:0] exp;   // {rgb, de, hs, vs}
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    function automatic logic [14:0] model_px(input logic [9:0] h, input logic [9:0] v,
                                             input logic de, input logic hs, input logic vs);
        logic [11:0] c;
        int dx, dy;
        dx = int'(h) - 240;
        dy = int'(v) - 80;
        if (de && dx >= 0 && dx < 160 && dy >= 0 && dy < 320)
            c = rom({mmap[(dy / 16) * 10 + dx / 16], 4'(dy % 16), 4'(dx % 16)});
        else if (de)
            c = BG;
        else
            c = 12'h000;
        return {c, de, hs, vs};
    endfunction

    always @(negedge clk) begin
        if (sbq.size() != 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check("sb_due", cyc, e.due);
            check("sb_rgb", rgb, e.exp[14:3]);
            check("sb_de",  de_o, e.exp[2]);
            check("sb_hs",  hs_o, e.exp[1]);
            check("sb_vs",  vs_o, e.exp[0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_px(input logic [9:0] h, input logic [9:0] v,
                          input logic de, input logic hs, input logic vs);
        hcnt = h; vcnt = v; de_i = de; hs_i = hs; vs_i = vs;
        sbq.push_back('{due: cyc + 3, exp: model_px(h, v, de, hs, vs)});
    endtask

    task automatic set_wr(input logic [3:0] x, input logic [4:0] y, input logic [3:0] t, input bit upd);
        cell_we = 1'b1; cell_x = x; cell_y = y; cell_tile = t;
        if (upd && x < 10 && y < 20) mmap[int'(y) * 10 + int'(x)] = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cell_we = 1'b0; board_clr = 1'b0;
        de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; hcnt = '0; vcnt = '0;
    endtask

    // Counts clear edges until clr_busy drops; a full clear is 200 edges.
    task automatic wait_clear(input string tag, input int already);
        int n;
        n = already;
        while (clr_busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, n, 200);
        for (int i = 0; i < 200; i++) mmap[i] = 4'h0;
    endtask

    task automatic sweep(input string tag);
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 10; c++) begin
                set_px(10'(240 + 16 * c + $urandom_range(0, 15)),
                       10'(80 + 16 * r + $urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
                tick();
                check({tag, "_ren"}, ram_ren, 1);
                check({tag, "_tile"}, ram_raddr[11:8], mmap[r * 10 + c]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [9:0] rh, rv;

    initial begin
        for (int i = 0; i < 200; i++) mmap[i] = 4'h0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb",  rgb, 0);
        check("rst_de",   de_o, 0);
        check("rst_hs",   hs_o, 0);
        check("rst_vs",   vs_o, 0);
        check("rst_ren",  ram_ren, 0);
        check("rst_busy", clr_busy, 1);
        rst = 1'b0;
        wait_clear("post_rst_clear_len", 0);
        sweep("post_rst");

        // top-left cell
        set_wr(4'd0, 5'd0, 4'd5, 1'b1); tick();
        set_px(10'd240, 10'd80, 1'b1, 1'b0, 1'b0); tick();
        check("tl_ren", ram_ren, 1);
        check("tl_addr", ram_raddr, 12'h500);

        // bottom-right cell, last pixel
        set_wr(4'd9, 5'd19, 4'd3, 1'b1); tick();
        set_px(10'd399, 10'd399, 1'b1, 1'b0, 1'b0); tick();
        check("br_ren", ram_ren, 1);
        check("br_addr", ram_raddr, 12'h3FF);

        // board edges, background and blanking
        set_px(10'd239, 10'd80, 1'b1, 1'b0, 1'b0); tick(); check("left_ren", ram_ren, 0);
        set_px(10'd400, 10'd80, 1'b1, 1'b0, 1'b0); tick(); check("right_ren", ram_ren, 0);
        set_px(10'd240, 10'd79, 1'b1, 1'b0, 1'b0); tick(); check("top_ren", ram_ren, 0);
        set_px(10'd240, 10'd400, 1'b1, 1'b0, 1'b0); tick(); check("bot_ren", ram_ren, 0);
        set_px(10'd300, 10'd100, 1'b0, 1'b0, 1'b0); tick(); check("blank_ren", ram_ren, 0);
        set_px(10'd100, 10'd500, 1'b0, 1'b1, 1'b0); tick();
        set_px(10'd100, 10'd500, 1'b0, 1'b0, 1'b1); tick();
        set_px(10'd100, 10'd500, 1'b0, 1'b1, 1'b1); tick();

        // random board contents and random pixel stream
        for (int i = 0; i < 30; i++) begin
            set_wr(4'($urandom_range(0, 9)), 5'($urandom_range(0, 19)), 4'($urandom), 1'b1);
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 1) begin
                rh = 10'(240 + $urandom_range(0, 159));
                rv = 10'(80 + $urandom_range(0, 319));
            end else begin
                rh = 10'($urandom_range(0, 639));
                rv = 10'($urandom_range(0, 479));
            end
            set_px(rh, rv, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 19) == 0);
            tick();
        end

        // out-of-range writes change nothing
        set_wr(4'd10, 5'd0,  4'd9, 1'b1); tick();
        set_wr(4'd0,  5'd20, 4'd9, 1'b1); tick();
        set_wr(4'd15, 5'd31, 4'd9, 1'b1); tick();
        sweep("bad_wr");

        // read and write of the same cell in one cycle: read sees old value
        set_wr(4'd0, 5'd0, 4'd5, 1'b1); tick();
        set_px(10'd245, 10'd83, 1'b1, 1'b0, 1'b0);
        set_wr(4'd0, 5'd0, 4'd6, 1'b1);
        tick();
        check("rw_old", ram_raddr, 12'h535);
        set_px(10'd245, 10'd83, 1'b1, 1'b0, 1'b0); tick();
        check("rw_new", ram_raddr, 12'h635);

        // clear drops writes and ignores a second request
        board_clr = 1'b1; tick();
        check("clr_busy_on", clr_busy, 1);
        set_wr(4'd2, 5'd2, 4'd7, 1'b0);
        board_clr = 1'b1;
        tick();
        wait_clear("clr_len", 1);
        sweep("after_clr");

        // reset in the middle of a clear restarts it; pixels run during clear
        set_wr(4'd3, 5'd4, 4'hA, 1'b1); tick();
        set_wr(4'd8, 5'd17, 4'hC, 1'b1); tick();
        sweep("pre_midrst");
        board_clr = 1'b1; tick();
        repeat (99) tick();
        hcnt = 10'd240; vcnt = 10'd80; de_i = 1'b1;
        tick();
        check("clr_px_ren", ram_ren, 1);
        check("clr_busy_mid", clr_busy, 1);
        rst = 1'b1;
        #2;
        check("midrst_ren", ram_ren, 0);
        check("midrst_busy", clr_busy, 1);
        check("midrst_rgb", rgb, 0);
        rst = 1'b0;
        wait_clear("midrst_clear_len", 0);
        sweep("after_midrst");

        repeat (5) tick();
        check("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
